// File: rtl/memprog_loader.sv
// Byte-stream loader for the CPU program memory: length header, then big-endian words
// written to consecutive addresses from 0. All outputs come straight from flops.
//
// state   | meaning
// IDLE    | waiting for start
// LEN_HI  | accept high byte of word count
// LEN_LO  | accept low byte of word count, validate it
// DAT_HI  | accept high byte of next word
// DAT_LO  | accept low byte of next word
// WRITE   | one-cycle write strobe into program memory
// DONE    | one-cycle completion pulse
// ERR     | bad word count, raise sticky err
module memprog_loader #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [15:0]   wd,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] DEPTH = 17'(1) << AW;

    state_t      state, state_nx;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [AW:0] cnt;
    logic [16:0] len_in;
    logic        xfer;
    logic        len_bad;
    logic        last_word;

    assign xfer      = in_valid && in_ready;
    assign len_in    = {1'b0, len_hi, in_data};
    assign len_bad   = (len_in == 17'd0) || (len_in > DEPTH);
    assign last_word = {{(16 - AW){1'b0}}, cnt} == ({1'b0, len} - 17'd1);
    assign wa        = cnt[AW-1:0];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LEN_HI;
            S_LEN_HI: if (xfer) state_nx = S_LEN_LO;
            S_LEN_LO: if (xfer) state_nx = len_bad ? S_ERR : S_DAT_HI;
            S_DAT_HI: if (xfer) state_nx = S_DAT_LO;
            S_DAT_LO: if (xfer) state_nx = S_WRITE;
            S_WRITE:  state_nx = last_word ? S_DONE : S_DAT_HI;
            S_DONE:   state_nx = S_IDLE;
            S_ERR:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wd       <= 16'd0;
            len_hi   <= 8'd0;
            len      <= 16'd0;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == S_LEN_HI) || (state_nx == S_LEN_LO) ||
                        (state_nx == S_DAT_HI) || (state_nx == S_DAT_LO);
            we       <= (state_nx == S_WRITE);
            busy     <= (state_nx != S_IDLE);
            done     <= (state_nx == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        cnt <= '0;
                    end
                end
                S_LEN_HI: if (xfer) len_hi <= in_data;
                S_LEN_LO: if (xfer) len <= len_in[15:0];
                S_DAT_HI: if (xfer) wd[15:8] <= in_data;
                S_DAT_LO: if (xfer) wd[7:0] <= in_data;
                S_WRITE:  if (!last_word) cnt <= cnt + 1'b1;
                S_ERR:    err <= 1'b1;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_memprog_loader.sv
// Directed bench for memprog_loader: writes are scored against a queue of expected
// {address, data} entries filled as each word is streamed in.
module tb_memprog_loader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready, we, busy, done, err;
    logic [AW-1:0] wa;
    logic [15:0]   wd;

    memprog_loader #(.AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [AW+15:0] exp_q[$];
    logic [15:0]    pl[$];
    int done_cnt = 0;
    int we_cnt = 0;
    int last_wa = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            we_cnt++;
            chk("ready_in_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) chk("unexpected_we", exp_q.size(), 32'd1);
            else begin
                chk("write", 32'({wa, wd}), 32'(exp_q.pop_front()));
                last_wa = int'(wa);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic run_load(input bit gaps, input bit mid_start);
        logic [15:0] nn = 16'(pl.size());
        int d0 = done_cnt;
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_after_start", 32'(in_ready), 32'd1);
        chk("err_after_start", 32'(err), 32'd0);
        send_byte(nn[15:8], gaps);
        send_byte(nn[7:0], gaps);
        for (int i = 0; i < pl.size(); i++) begin
            if (mid_start && i == 1) pulse_start();
            exp_q.push_back({AW'(i), pl[i]});
            send_byte(pl[i][15:8], gaps);
            send_byte(pl[i][7:0], gaps);
        end
        @(negedge clk);
        chk("last_we", 32'(we), 32'd1);
        chk("last_wa", 32'(wa), 32'(int'(nn) - 1));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_single", 32'(done), 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("done_count", done_cnt, d0 + 1);
    endtask

    task automatic bad_len(input logic [7:0] hi, input logic [7:0] lo);
        int w0 = we_cnt;
        pulse_start();
        chk("bad_err_cleared", 32'(err), 32'd0);
        send_byte(hi, 1'b0);
        send_byte(lo, 1'b0);
        chk("bad_busy_in_err", 32'(busy), 32'd1);
        chk("bad_ready_in_err", 32'(in_ready), 32'd0);
        chk("bad_err_not_yet", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("bad_err_set", 32'(err), 32'd1);
        chk("bad_busy_low", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("bad_err_sticky", 32'(err), 32'd1);
        chk("bad_no_we", we_cnt, w0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_wa"}, 32'(wa), 32'd0);
        chk({tag, "_wd"}, 32'(wd), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1 reset_n = 1'b1;

        pl = '{16'h1234, 16'hABCD, 16'h00FF};
        run_load(1'b0, 1'b0);

        pl = '{16'h1234, 16'hABCD, 16'h00FF};
        run_load(1'b1, 1'b0);

        bad_len(8'h00, 8'h00);
        bad_len(8'h04, 8'h01);
        pl = '{16'h0F0F};
        run_load(1'b0, 1'b0);

        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(16'($urandom));
        run_load(1'b1, 1'b1);

        pl.delete();
        for (int i = 0; i < 1024; i++) pl.push_back(16'(i * 37) ^ 16'hA55A);
        w0 = we_cnt;
        run_load(1'b0, 1'b0);
        chk("full_last_wa", last_wa, 1023);
        chk("full_we_count", we_cnt - w0, 1024);

        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({AW'(i), 16'h1111 * 16'(i + 1)});
            send_byte(8'h11 * 8'(i + 1), 1'b0);
            send_byte(8'h11 * 8'(i + 1), 1'b0);
        end
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        chk("midload_queue", exp_q.size(), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        pl = '{16'hBEEF};
        run_load(1'b0, 1'b0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/memprog_loader.md
# memprog_loader

Byte-stream program loader that fills the CPU program memory (`memprog`, 1024 × 16 bit). It receives a length header and then program words as bytes over a valid/ready stream, assembles 16-bit words and drives a synchronous write port into program memory at consecutive addresses from 0. `busy` holds the CPU off while a load is in progress. `done` and `err` report the outcome.

## Interface
Parameters:
- `AW`, 10, program memory address width; depth = 2^AW words.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle pulse that begins a load; sampled only in IDLE.
- `in_valid`  input  1  `in_data` holds a byte.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `we`  output  1  program memory write enable, one-cycle pulse per word.
- `wa`  output  AW  program memory write address.
- `wd`  output  16  program memory write data.
- `busy`  output  1  load in progress; CPU is held in reset while high.
- `done`  output  1  one-cycle pulse when the final word has been written.
- `err`  output  1  sticky; bad length header; cleared by the next accepted `start`.

## Operation
- A byte transfers on a rising edge where `in_valid && in_ready`.
- Stream format, all values big-endian:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - Then N words, each sent as high byte then low byte.
- States:
  - IDLE: `start` → LEN_HI, clear `err`, address counter ← 0.
  - LEN_HI: on transfer, latch the high byte → LEN_LO.
  - LEN_LO: on transfer, latch N. If N == 0 or N > 2^AW → ERR, else → DAT_HI.
  - DAT_HI: on transfer, latch `wd[15:8]` → DAT_LO.
  - DAT_LO: on transfer, latch `wd[7:0]` → WRITE.
  - WRITE: `we` = 1 for one cycle at `wa` = address counter. If counter == N−1 → DONE, else counter++ and → DAT_HI.
  - DONE: `done` = 1 for one cycle → IDLE.
  - ERR: set `err` → IDLE.
- `in_ready` is 1 only in LEN_HI, LEN_LO, DAT_HI and DAT_LO. It is 0 in every other state, including WRITE.
- `busy` is 1 in every state except IDLE.
- Address counter width is AW+1 internally; N is compared at full width.
- Writes cover addresses 0..N−1 only; the address never wraps. Words above N−1 keep their previous contents.
- `start` outside IDLE is ignored.
- `in_valid` with `in_ready` low is not consumed; the byte is presented again by the sender.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready` = 0, `we` = 0, `wa` = 0, `wd` = 0.
  - `busy` = 0, `done` = 0, `err` = 0.
- `start` high at edge k → `busy` = 1 and `in_ready` = 1 from cycle k+1.
- LEN_LO accepted at edge j:
  - Valid N → DAT_HI from j+1.
  - Invalid N → ERR at j+1; `err` = 1 and `busy` = 0 from j+2.
- Low byte accepted at edge m → `we` = 1 during cycle m+1, with `wa`/`wd` stable through that cycle. Program memory captures the word at edge m+2.
- Maximum throughput is one word per 3 cycles.
- Last word: `we` in cycle m+1, `done` in cycle m+2, `busy` = 0 from cycle m+3.
- `reset_n` low at any time, including mid-load or during a `we` pulse, returns all outputs to reset values immediately. Words already written stay in memory. No partial write is guaranteed for the word in flight.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Three-word load: `start`, then stream 00 03 12 34 AB CD 00 FF with `in_valid` held high → `we` pulses at `wa` = 0, 1, 2 with `wd` = 1234, ABCD, 00FF; `done` pulses once; `busy` falls the cycle after `done`.
- Backpressure and gaps: same stream with `in_valid` randomly deasserted → identical writes; no byte is lost or duplicated; `in_ready` is 0 in every WRITE cycle.
- Bad length: header 00 00, and separately 04 01 (1025) → no `we`; `err` = 1 and stays 1; next `start` clears it.
- Full memory: N = 0x0400 → 1024 writes; last `wa` = 1023; no write to address 0 after the first one.
- `start` pulsed mid-load → ignored; load completes normally.
- Reset mid-load: `reset_n` low after 2 of 5 words → all outputs at reset values; a new `start` with 00 01 BE EF writes BEEF at address 0.
